// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// No logic here beyond a word-alignment helper.
package arm_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory request/response and datapath instruction handshakes of the fetch queue.
// master = fetch queue side, slave = memory/datapath side.
interface ifetch_queue_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output req_valid, req_addr, instr_valid, instr, instr_pc,
    input  req_ready, rsp_valid, rsp_data, instr_ready
  );

  modport slave (
    input  req_valid, req_addr, instr_valid, instr, instr_pc,
    output req_ready, rsp_valid, rsp_data, instr_ready
  );
endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetch entries; push visible at head one edge later, no bypass.
// Push while full is accepted only together with a pop; clear empties it in one edge.
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_dat_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  // Empty head reads as zero so the datapath never sees stale storage.
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Credit-limited sequential fetcher feeding a FIFO of {instr, pc}; response-to-instr latency 1 cycle.
// Requests stall when outstanding + buffered reaches DEPTH; flush drops buffered and in-flight words.
module ifetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic [31:0]    redirect_pc,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, occ;
  logic [CW:0]   credit_used;
  logic          req_acc, rsp_ok, push, pop, full, empty;
  fetch_entry_t  head, push_dat;

  assign credit_used   = {1'b0, outst_q} + {1'b0, occ};
  assign bus.req_valid = reset && !flush && (credit_used < (CW+1)'(DEPTH));
  assign bus.req_addr  = fetch_pc_q;
  assign req_acc       = bus.req_valid && bus.req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = bus.rsp_valid && (outst_q != '0);
  assign push     = rsp_ok && !flush && (discard_q == '0);
  assign pop      = bus.instr_valid && bus.instr_ready && !flush;
  assign push_dat = '{instr: bus.rsp_data, pc: rsp_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (flush) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      outst_d    = outst_q - CW'(rsp_ok);
      discard_d  = outst_q - CW'(rsp_ok);
    end else begin
      if (req_acc) fetch_pc_d = fetch_pc_q + PC_STEP;
      outst_d = outst_q + CW'(req_acc) - CW'(rsp_ok);
      if (rsp_ok) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 rsp_pc_d  = rsp_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .clear_i    (flush),
    .push_i     (push && (!full || pop)),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (occ)
  );

  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed bench for ifetch_queue against a queue-based memory and fetch model.
module tb_ifetch_queue;
  import arm_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       inflight[$];   // accepted requests not yet answered by memory
  logic [31:0] m_buf[$];      // PCs of live words the queue should hold, head first
  logic [31:0] m_fetch_pc = '0;
  int          m_epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  logic [31:0] acc_addrs[$];
  logic [31:0] pop_pcs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_rv();
    return reset && !flush && ((inflight.size() + m_buf.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] exp_head_pc();
    return (m_buf.size() > 0) ? m_buf[0] : 32'h0;
  endfunction

  // One clock: sample handshakes, advance the model and memory, drive the next response.
  task automatic cycle();
    bit    acc, rsp, pop;
    mreq_t e;
    int    d;
    #1;
    acc = exp_rv() && bus.req_ready;
    rsp = bus.rsp_valid;
    pop = (m_buf.size() > 0) && bus.instr_ready;
    if (acc) acc_addrs.push_back(m_fetch_pc);
    if (pop && !flush && reset) pop_pcs.push_back(m_buf[0]);
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      inflight.delete();
      m_buf.delete();
      m_fetch_pc = 32'h0;
      last_due = 0;
    end else if (flush) begin
      m_buf.delete();
      m_fetch_pc = redirect_pc & ~32'd3;
      m_epoch++;
      if (rsp) e = inflight.pop_front();
    end else begin
      if (pop) void'(m_buf.pop_front());
      if (rsp) begin
        e = inflight.pop_front();
        if (e.epoch == m_epoch) m_buf.push_back(e.addr);
      end
      if (acc) begin
        d = cyc - 1 + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        inflight.push_back('{addr: m_fetch_pc, epoch: m_epoch, due: d});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    flush = 1'b0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = mem_word(inflight[0].addr);
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    acc_addrs.delete();
    pop_pcs.delete();
  endtask

  task automatic test_reset();
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b0;
    reset = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
    checks++;
    if (bus.req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 00000000", bus.req_addr); end
    checks++;
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    checks++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got instr=%h pc=%h want 0/0", bus.instr, bus.instr_pc);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got valid=%b addr=%h want 1/00000000", bus.req_valid, bus.req_addr);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    lat = 1;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (bus.instr_valid !== (i + 1 >= 2)) begin
        errors++; $display("FAIL stream_valid: cycle %0d got %b want %b", i + 1, bus.instr_valid, (i + 1 >= 2));
      end
    end
    checks++;
    if (acc_addrs.size() != 20 || pop_pcs.size() != 18) begin
      errors++; $display("FAIL stream_counts: got req=%0d pop=%0d want 20/18", acc_addrs.size(), pop_pcs.size());
    end
    for (int j = 0; j < 18 && j < pop_pcs.size(); j++)
      if (acc_addrs[j] !== 32'(4 * j) || pop_pcs[j] !== 32'(4 * j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stream_order: got %0d out-of-sequence entries want 0", bad); end
  endtask

  task automatic test_stall();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (acc_addrs.size() != 4 || bus.req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_credit: got accepted=%0d req_valid=%b want 4/0", acc_addrs.size(), bus.req_valid);
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL stall_head: got valid=%b pc=%h instr=%h want 1/00000000/%h",
                         bus.instr_valid, bus.instr_pc, bus.instr, mem_word(32'h0));
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (pop_pcs.size() < 4 || pop_pcs[0] !== 32'h0 || pop_pcs[1] !== 32'h4 ||
        pop_pcs[2] !== 32'h8 || pop_pcs[3] !== 32'hC) begin
      errors++; $display("FAIL stall_release: got %0d pops first=%h want 0,4,8,c",
                         pop_pcs.size(), (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hx);
    end
  endtask

  task automatic test_flush_late();
    int n;
    lat = 3;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    flush = 1'b1;
    redirect_pc = 32'h100;
    pop_pcs.delete();
    cycle();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_late_redirect: got valid=%b addr=%h iv=%b want 1/00000100/0",
                         bus.req_valid, bus.req_addr, bus.instr_valid);
    end
    n = 0;
    while (pop_pcs.size() < 2 && n < 30) begin
      cycle();
      n++;
      checks++;
      if (bus.instr_valid !== (m_buf.size() > 0) || bus.instr_pc !== exp_head_pc()) begin
        errors++; $display("FAIL flush_late_head: got iv=%b pc=%h want %b/%h",
                           bus.instr_valid, bus.instr_pc, (m_buf.size() > 0), exp_head_pc());
      end
    end
    checks++;
    if (pop_pcs.size() < 2 || pop_pcs[0] !== 32'h100 || pop_pcs[1] !== 32'h104) begin
      errors++; $display("FAIL flush_late_order: got %0d pops first=%h want 00000100,00000104",
                         pop_pcs.size(), (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hx);
    end
  endtask

  task automatic test_flush_rsp();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    cycle();
    flush = 1'b1;
    redirect_pc = 32'h203;
    pop_pcs.delete();
    cycle();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.req_addr !== 32'h200 || bus.req_valid !== 1'b1) begin
      errors++; $display("FAIL flush_rsp: got iv=%b addr=%h rv=%b want 0/00000200/1",
                         bus.instr_valid, bus.req_addr, bus.req_valid);
    end
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (pop_pcs.size() < 1 || pop_pcs[0] !== 32'h200) begin
      errors++; $display("FAIL flush_rsp_next: got %0d pops first=%h want 00000200",
                         pop_pcs.size(), (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    lat = 2;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    flush = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    for (int i = 0; i < 12; i++) cycle();
    checks++;
    if (acc_addrs.size() < 3 || acc_addrs[0] !== 32'hFFFF_FFF8 || acc_addrs[1] !== 32'hFFFF_FFFC ||
        acc_addrs[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_req: got %0d reqs third=%h want fffffff8,fffffffc,00000000",
                         acc_addrs.size(), (acc_addrs.size() > 2) ? acc_addrs[2] : 32'hx);
    end
    checks++;
    if (pop_pcs.size() < 3 || pop_pcs[0] !== 32'hFFFF_FFF8 || pop_pcs[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_pop: got %0d pops third=%h want 00000000",
                         pop_pcs.size(), (pop_pcs.size() > 2) ? pop_pcs[2] : 32'hx);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    lat = 1;
    bus.req_ready = 1'b1;
    bus.instr_ready = 1'b0;
    do_reset();
    while (m_buf.size() < 2 && n < 10) begin cycle(); n++; end
    checks++;
    if (m_buf.size() != 2 || bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset_fill: got iv=%b after %0d cycles want 1", bus.instr_valid, n);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.req_addr !== 32'h0 || bus.req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got iv=%b addr=%h rv=%b want 0/00000000/0",
                         bus.instr_valid, bus.req_addr, bus.req_valid);
    end
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    pop_pcs.delete();
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (pop_pcs.size() < 1 || pop_pcs[0] !== 32'h0) begin
      errors++; $display("FAIL mid_reset_restart: got %0d pops first=%h want 00000000",
                         pop_pcs.size(), (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    lat = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) lat = $urandom_range(1, 4);
      bus.req_ready   = ($urandom_range(0, 3) != 0);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        redirect_pc = $urandom;
      end
      #1;
      checks++;
      if (bus.req_valid !== exp_rv() || bus.req_addr !== m_fetch_pc) begin
        errors++; $display("FAIL rnd_req: cycle %0d got valid=%b addr=%h want %b/%h",
                           cyc, bus.req_valid, bus.req_addr, exp_rv(), m_fetch_pc);
      end
      checks++;
      if (bus.instr_valid !== (m_buf.size() > 0) ||
          (m_buf.size() > 0 && (bus.instr_pc !== exp_head_pc() || bus.instr !== mem_word(exp_head_pc())))) begin
        errors++; $display("FAIL rnd_head: cycle %0d got iv=%b pc=%h instr=%h want %b/%h/%h",
                           cyc, bus.instr_valid, bus.instr_pc, bus.instr, (m_buf.size() > 0),
                           exp_head_pc(), mem_word(exp_head_pc()));
      end
      cycle();
    end
  endtask

  initial begin
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_data    = '0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_late();
    test_flush_rsp();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue sitting directly upstream of the single-cycle ARM datapath. It generates sequential fetch addresses, issues them to an instruction memory with variable response latency, and buffers returned words with their PC. It presents one instruction per cycle to the datapath under a valid/ready handshake. A branch redirect (datapath PCSrc) flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, queue entries; also the maximum number of outstanding plus buffered fetches (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
- flush  in  1  redirect strobe (branch taken / PC written)
- redirect_pc  in  32  new fetch address, sampled when flush=1
- req_valid  out  1  fetch request valid
- req_addr  out  32  fetch address, word aligned
- req_ready  in  1  memory accepts request
- rsp_valid  in  1  response word valid; responses return in request order, ≥1 cycle after acceptance
- rsp_data  in  32  instruction word
- instr_valid  out  1  head entry valid
- instr  out  32  head instruction
- instr_pc  out  32  address of head instruction
- instr_ready  in  1  datapath consumes head

## Operation
- Registers: fetch_pc (next request address), rsp_pc (address of next expected response), outstanding count, discard count, FIFO of {instr, pc}; counters $clog2(DEPTH+1) bits.
- Credit rule: req_valid = !flush && (outstanding + occupancy < DEPTH). req_addr = fetch_pc.
- Request accept (req_valid && req_ready): fetch_pc += 4 (mod 2^32, wraps silently), outstanding += 1.
- Response (rsp_valid): outstanding -= 1. If discard > 0, drop the word and decrement discard. Otherwise push {rsp_data, rsp_pc} and set rsp_pc += 4.
- Pop (instr_valid && instr_ready): remove head.
- The FIFO never overflows because of credits; a response arriving when outstanding==0 is a protocol error and is ignored.
- Flush (priority over everything in the same cycle):
  - FIFO cleared and any same-cycle pop ignored.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}.
  - discard = outstanding minus (1 if rsp_valid this cycle), and outstanding is set to the same value.
  - A response arriving in the flush cycle is dropped.
  - req_valid is 0 in the flush cycle.
- Back-to-back flushes: each recomputes discard from the current outstanding count; the latest redirect_pc wins.
- Push and pop in the same cycle are allowed at any occupancy, including full.

## Timing
- Reset values:
  - req_valid 0; req_addr RESET_PC; instr_valid 0; instr 0; instr_pc 0.
  - fetch_pc and rsp_pc = RESET_PC; outstanding, discard and occupancy 0.
- First request: req_valid=1 in the first cycle with reset==1, address RESET_PC.
- Response to instr_valid: 1 cycle; a word is pushed on edge N and visible from N. There is no combinational bypass from rsp to instr.
- Flush to new request: the request for redirect_pc is presented the cycle after flush, if credits allow.
- Throughput: 1 instr/cycle sustained when memory latency plus 1 ≤ DEPTH and req_ready=1.
- instr, instr_pc and instr_valid are registered/FIFO outputs, stable while instr_valid && !instr_ready.
- Reset asserted mid-operation: all state returns to reset values at that edge. In-flight responses after reset are not discarded; the memory must be reset together.

## Structure
- Package arm_fetch_pkg holds RESET_PC default, PC_STEP=32'd4, and typedef fetch_entry_t {instr[31:0], pc[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, clear input, push/pop, full/empty and count outputs.
- Credit, discard and PC logic live in ifetch_queue.

## Test plan
- Reset, req_ready=1, memory latency 1, instr_ready=1:
  - requests go to 0, 4, 8, …
  - instr_pc sequence 0, 4, 8, and instr equals the memory contents
  - one instruction per cycle after a 2-cycle startup
- instr_ready=0 for 10 cycles, latency 1:
  - exactly 4 requests are accepted, then req_valid=0
  - head stays instr_pc=0
  - after release, entries pop in order 0, 4, 8, 12
- Latency 3 with 3 outstanding, then flush with redirect_pc=32'h100:
  - the 3 late responses are dropped
  - the next instr_pc is 32'h100, followed by 32'h104
- Flush in the same cycle as rsp_valid and instr_ready=1 with redirect_pc=32'h203:
  - the response is dropped and the queue is empty next cycle
  - req_addr becomes 32'h200
- redirect_pc=32'hFFFF_FFF8: request addresses are FFFF_FFF8, FFFF_FFFC, then wrap to 0000_0000.
- reset=0 for one cycle mid-stream with 2 entries buffered: instr_valid=0 and req_addr=RESET_PC the next cycle.
